bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
// PURPOSE
//   Digit-serial multi-digit BCD subtractor: diff = A - B - bin, in ten's-complement form.
//   Processes one BCD digit per clock, least-significant digit first, using a start/busy/done handshake.
//   It is the inverse companion of the lab's combinational BCD digit adder.
//   It sits between operand registers and the 7-segment display path of the calculator datapath.
// PARAMETERS
//   DIGITS   4   number of BCD digits per operand (>=1); operand width is 4*DIGITS
// PORTS
//   clk      in   1          rising-edge clock, single clock domain
//   rst_n    in   1          synchronous reset, active low
//   start    in   1          request; sampled only in IDLE
//   a        in   4*DIGITS   minuend, packed BCD, digit 0 = a[3:0]
//   b        in   4*DIGITS   subtrahend, packed BCD
//   bin      in   1          borrow in
//   busy     out  1          high in CALC and DONE
//   done     out  1          one-cycle pulse; result valid from this cycle on
//   diff     out  4*DIGITS   packed BCD result, held until the next completion
//   bout     out  1          borrow out (1 = A < B + bin; diff is the ten's complement)
//   invalid  out  1          some input digit was >9; held with diff
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-low.
//   Reset (rst_n=0 at a clk edge):
//     - state=IDLE; busy, done, diff, bout, invalid all 0.
//     - Working registers and digit index cleared.
//     - Reset overrides every other input.
//   FSM, three states:
//     - IDLE -> CALC when start=1.
//     - CALC -> DONE after the last digit.
//     - DONE -> IDLE unconditionally, after one cycle.
//   Capture (edge E0, IDLE and start=1):
//     - Latch a, b and bin into working registers; digit index k=0.
//     - Check all 2*DIGITS input digits for >9 and latch the result as an error flag.
//     - a, b and bin may change after E0 without effect.
//   CALC, edge E(k+1), for k = 0..DIGITS-1:
//     - t = a_k - b_k - brw (brw = bin for k=0), evaluated signed, 5 bits.
//     - If t < 0: d_k = t + 10 and brw = 1. Otherwise d_k = t and brw = 0.
//     - d_k is always in 0..9 when the input digits are valid.
//   Completion, edge E_DIGITS:
//     - diff <= {d_(DIGITS-1)..d_0}; bout <= final brw; invalid <= error flag.
//     - If the error flag is set: diff <= 0, bout <= 0, invalid <= 1. Latency is unchanged.
//     - done=1 for the cycle following E_DIGITS only (state DONE).
//   Outputs and handshake:
//     - diff, bout and invalid update only at completion and are stable during CALC.
//     - Latency: start accepted at E0 -> done high between E_DIGITS and E_DIGITS+1.
//     - Throughput: one operation per DIGITS+2 cycles.
//     - start is ignored in CALC and DONE. No queuing; a request must be re-asserted in IDLE.
//   Boundaries:
//     - start held high continuously: a new operation starts on each IDLE cycle.
//     - Reset mid-CALC: the operation is discarded; outputs clear to 0 with no done pulse.
//     - 0 - 0 with bin=1 -> all nines, bout=1.
//     - DIGITS=1: done goes high 1 edge after capture.
// TESTING (DIGITS=4)
//   1. a=0x5432, b=0x1234, bin=0, start -> done 4 edges later; diff=0x4198, bout=0, invalid=0.
//   2. a=0x0000, b=0x0001, bin=0 -> diff=0x9999, bout=1. Also a=0x1000, b=0x0001 -> diff=0x0999, bout=0.
//   3. a=0x0005, b=0x0005, bin=1 -> diff=0x9999, bout=1. Also a=0x9999, b=0x9999, bin=0 -> diff=0x0000, bout=0.
//   4. a=0x00A0, b=0x0001 -> diff=0x0000, bout=0, invalid=1; done after the same latency.
//   5. Pulse start again in CALC with different a -> ignored; result still matches the first operands; busy pattern 1,1,1,1,1 then 0.
//   6. rst_n=0 after 2 CALC cycles -> next cycle busy=0, done=0, diff=0; a following start completes normally.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial BCD subtractor, diff = a - b - bin in ten's complement
// One BCD digit per clock, least-significant first, with a start/busy/done handshake.
module bcd_serial_subtractor #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   input  logic                bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] diff,
   output logic                bout,
   output logic                invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  acc;
   logic          brw;
   logic          err;
   logic [KW-1:0] k;

   logic          in_err;
   logic [4:0]    t;
   logic [3:0]    d;
   logic          brw_nxt;
   logic [W-1:0]  acc_nxt;
   logic          last;

   // Any operand digit outside 0..9 poisons the whole operation.
   always_comb begin
      in_err = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
            in_err = 1'b1;
         end
      end
   end

   // Signed 5-bit digit difference; a negative result borrows ten from the next digit.
   always_comb begin
      t       = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, brw};
      brw_nxt = t[4];
      d       = t[4] ? (t[3:0] + 4'd10) : t[3:0];
   end

   // Result digits enter at the top, so after DIGITS steps digit 0 sits at [3:0].
   generate
      if (DIGITS == 1) begin : g_acc_one
         assign acc_nxt = d;
      end else begin : g_acc_many
         assign acc_nxt = {d, acc[W-1:4]};
      end
   endgenerate

   assign last = (k == KW'(DIGITS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         acc     <= '0;
         brw     <= 1'b0;
         err     <= 1'b0;
         k       <= '0;
         diff    <= '0;
         bout    <= 1'b0;
         invalid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  brw  <= bin;
                  err  <= in_err;
                  acc  <= '0;
                  k    <= '0;
               end
            end
            CALC: begin
               a_sh <= a_sh >> 4;
               b_sh <= b_sh >> 4;
               acc  <= acc_nxt;
               brw  <= brw_nxt;
               k    <= k + KW'(1);
               if (last) begin
                  diff    <= err ? '0 : acc_nxt;
                  bout    <= err ? 1'b0 : brw_nxt;
                  invalid <= err;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb/tb_bcd_serial_subtractor.sv - self-checking bench for bcd_serial_subtractor (DIGITS=4)
// Expected results come from integer arithmetic on the decimal values of the operands.
module tb_bcd_serial_subtractor;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         invalid;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .bin     (bin),
      .busy    (busy),
      .done    (done),
      .diff    (diff),
      .bout    (bout),
      .invalid (invalid)
   );

   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                 output logic [W-1:0] md, output logic mbo, output logic minv);
      int av, bv, r, m;
      logic bad;
      logic [3:0] da, db;
      av = 0; bv = 0; m = 1; bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         da = ma[4*i +: 4];
         db = mb[4*i +: 4];
         if (da > 4'd9 || db > 4'd9) bad = 1'b1;
         av = av + int'(da) * m;
         bv = bv + int'(db) * m;
         m  = m * 10;
      end
      r = av - bv - int'(mbin);
      mbo = 1'b0;
      if (r < 0) begin
         r   = r + m;
         mbo = 1'b1;
      end
      md = '0;
      for (int i = 0; i < DIGITS; i++) begin
         md[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      minv = bad;
      if (bad) begin
         md  = '0;
         mbo = 1'b0;
      end
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(9));
      return v;
   endfunction

   // Entered #1 after a rising edge with the DUT idle; returns #1 after the edge that re-enters IDLE.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                         output logic [W-1:0] od, output logic obo, output logic oinv, output int lat);
      a = oa; b = ob; bin = obin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      od = diff; obo = bout; oinv = invalid;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; a = 16'h5432; b = 16'h1234;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({busy, done, diff, bout, invalid} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b diff=%h bout=%b invalid=%b, want all zero",
                  busy, done, diff, bout, invalid);
      end
      start = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [7] = '{16'h5432, 16'h0000, 16'h1000, 16'h0005, 16'h9999, 16'h00A0, 16'h0000};
      logic [W-1:0] tb_ [7] = '{16'h1234, 16'h0001, 16'h0001, 16'h0005, 16'h9999, 16'h0001, 16'h0000};
      logic         tbin [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [W-1:0] ed [7] = '{16'h4198, 16'h9999, 16'h0999, 16'h9999, 16'h0000, 16'h0000, 16'h9999};
      logic         ebo [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic         einv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] d;
      logic bo, inv;
      int lat;
      for (int i = 0; i < 7; i++) begin
         run_op(ta[i], tb_[i], tbin[i], d, bo, inv, lat);
         tests++;
         if ({d, bo, inv} !== {ed[i], ebo[i], einv[i]}) begin
            fails++;
            $display("FAIL directed_%0d: diff=%h bout=%b invalid=%b, want diff=%h bout=%b invalid=%b",
                     i, d, bo, inv, ed[i], ebo[i], einv[i]);
         end
         tests++;
         if (lat !== DIGITS) begin
            fails++;
            $display("FAIL directed_latency_%0d: %0d edges, want %0d", i, lat, DIGITS);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb, d, md;
      logic rbin, bo, inv, mbo, minv;
      int lat;
      for (int n = 0; n < 40; n++) begin
         ra = rand_bcd(); rb = rand_bcd(); rbin = 1'($urandom);
         if (n % 5 == 4) begin
            if ($urandom_range(1) == 0) ra[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
            else                        rb[4*$urandom_range(DIGITS-1) +: 4] = 4'($urandom_range(15, 10));
         end
         model(ra, rb, rbin, md, mbo, minv);
         run_op(ra, rb, rbin, d, bo, inv, lat);
         tests++;
         if ({d, bo, inv, lat} !== {md, mbo, minv, DIGITS}) begin
            fails++;
            $display("FAIL random_%0d: a=%h b=%h bin=%b got diff=%h bout=%b invalid=%b lat=%0d, want %h %b %b lat=%0d",
                     n, ra, rb, rbin, d, bo, inv, lat, md, mbo, minv, DIGITS);
         end
      end
   endtask

   task automatic test_start_in_calc();
      logic [5:0] busy_seq;
      logic [W-1:0] got_d;
      logic got_bo;
      int done_at;
      done_at = -1; got_d = 'x; got_bo = 1'bx;
      a = 16'h5432; b = 16'h1234; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 6; j++) begin
         busy_seq[5-j] = busy;
         if (done === 1'b1) begin
            done_at = j; got_d = diff; got_bo = bout;
         end
         if (j == 1) begin
            a = 16'h9999; b = 16'h0000; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      tests++;
      if (busy_seq !== 6'b111110) begin
         fails++;
         $display("FAIL calc_busy_pattern: %b, want 111110", busy_seq);
      end
      tests++;
      if ({done_at, got_d, got_bo} !== {32'sd4, 16'h4198, 1'b0}) begin
         fails++;
         $display("FAIL calc_start_ignored: done_at=%0d diff=%h bout=%b, want 4 4198 0", done_at, got_d, got_bo);
      end
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL calc_no_queue: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] o1a, o1b, o2a, o2b, m1, m2, r1, r2;
      logic mb1, mb2, mi1, mi2;
      int t1, t2, ndone;
      o1a = rand_bcd(); o1b = rand_bcd(); o2a = rand_bcd(); o2b = rand_bcd();
      model(o1a, o1b, 1'b0, m1, mb1, mi1);
      model(o2a, o2b, 1'b0, m2, mb2, mi2);
      t1 = -1; t2 = -1; ndone = 0; r1 = 'x; r2 = 'x;
      a = o1a; b = o1b; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      a = o2a; b = o2b;
      for (int j = 1; j <= 14; j++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin t1 = j; r1 = diff; end
            if (ndone == 2) begin t2 = j; r2 = diff; end
         end
         if (j == 11) start = 1'b0;
      end
      tests++;
      if (t1 !== 4 || t2 !== 10 || ndone !== 2) begin
         fails++;
         $display("FAIL b2b_timing: done at %0d and %0d (%0d pulses), want 4 and 10 (2 pulses)", t1, t2, ndone);
      end
      tests++;
      if (r1 !== m1 || r2 !== m2) begin
         fails++;
         $display("FAIL b2b_results: %h %h, want %h %h", r1, r2, m1, m2);
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [W-1:0] d, md;
      logic bo, inv, mbo, minv;
      int lat, spurious;
      run_op(16'h5432, 16'h1234, 1'b0, d, bo, inv, lat);
      a = 16'h1111; b = 16'h0000; bin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({busy, done, diff, bout, invalid} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid_calc: busy=%b done=%b diff=%h bout=%b invalid=%b, want all zero",
                  busy, done, diff, bout, invalid);
      end
      rst_n = 1'b1;
      spurious = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      tests++;
      if (spurious !== 0) begin
         fails++;
         $display("FAIL reset_no_done: %0d cycles busy/done after reset, want 0", spurious);
      end
      model(16'h3000, 16'h0472, 1'b1, md, mbo, minv);
      run_op(16'h3000, 16'h0472, 1'b1, d, bo, inv, lat);
      tests++;
      if ({d, bo, inv, lat} !== {md, mbo, minv, DIGITS}) begin
         fails++;
         $display("FAIL after_reset_op: diff=%h bout=%b invalid=%b lat=%0d, want %h %b %b %0d",
                  d, bo, inv, lat, md, mbo, minv, DIGITS);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_in_calc();
      test_back_to_back();
      test_reset_mid_calc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
